// File: rtl/ff_wr_arbiter.sv
// ff_wr_arbiter
//   Round-robin write arbiter and sequencer for a shared N-bit register.
//   REQS requesters compete for the write port. Each arbitration round grants
//   one requester for a single LOAD cycle. The register then loads that
//   requester's data, and a settle window of HOLD_CYCLES idle cycles follows.
//
// Ports
//   clk      rising-edge clock
//   res      asynchronous, active-high reset
//   req      per-requester level request, held until granted
//   din      requester data, requester i at [i*N +: N]
//   gnt      one-hot grant, registered, high for the LOAD cycle only
//   busy     registered, high whenever the sequencer is not IDLE
//   q        shared register contents
//   last_id  index of the last requester whose write committed
//   wr_cnt   committed-write count, wraps modulo 2^CNT_W
module ff_wr_arbiter #(
  parameter int N           = 8,
  parameter int REQS        = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic [REQS-1:0]         req,
  input  logic [REQS*N-1:0]       din,
  output logic [REQS-1:0]         gnt,
  output logic                    busy,
  output logic [N-1:0]            q,
  output logic [$clog2(REQS)-1:0] last_id,
  output logic [CNT_W-1:0]        wr_cnt
);

  localparam int ID_W = $clog2(REQS);
  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [ID_W-1:0] ID_MAX    = ID_W'(REQS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] sel;
  logic [ID_W-1:0] winner;
  logic [HC_W-1:0] hold_cnt;
  logic            arb;
  logic            commit;

  // First set request searching upward from last+1, wrapping REQS-1 -> 0.
  function automatic logic [ID_W-1:0] rr_pick(input logic [REQS-1:0] r,
                                              input logic [ID_W-1:0] last);
    logic [ID_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= REQS; k++) begin
      idx = (int'(last) + k) % REQS;
      if (!found && r[idx]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    state_nxt = state;
    arb       = 1'b0;
    commit    = 1'b0;
    winner    = rr_pick(req, last_id);
    case (state)
      IDLE: begin
        if (|req) begin
          arb       = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        // A requester that drops req during its LOAD cycle forfeits the write.
        if (req[sel]) begin
          commit    = 1'b1;
          state_nxt = (HOLD_CYCLES == 0) ? IDLE : HOLD;
        end else begin
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (hold_cnt == HOLD_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      gnt      <= '0;
      busy     <= 1'b0;
      q        <= '0;
      last_id  <= ID_MAX;
      wr_cnt   <= '0;
      sel      <= '0;
      hold_cnt <= '0;
    end else begin
      busy <= (state_nxt != IDLE);
      // Grant lasts exactly the LOAD cycle: set on arbitration, cleared next edge.
      if (arb) begin
        gnt <= REQS'(1) << winner;
        sel <= winner;
      end else begin
        gnt <= '0;
      end
      // Data is sampled on the LOAD-exit edge, not at grant time.
      if (commit) begin
        q       <= din[int'(sel)*N +: N];
        last_id <= sel;
        wr_cnt  <= wr_cnt + 1'b1;
      end
      if (state == HOLD) hold_cnt <= hold_cnt + 1'b1;
      else               hold_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_ff_wr_arbiter.sv
module tb_ff_wr_arbiter;

  logic        clk = 1'b0;
  logic        res_a, res_b;
  logic [3:0]  req_a, req_b;
  logic [31:0] din_a, din_b;
  logic [3:0]  gnt_a, gnt_b;
  logic        busy_a, busy_b;
  logic [7:0]  q_a, q_b;
  logic [1:0]  last_a, last_b;
  logic [7:0]  cnt_a;
  logic [3:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ff_wr_arbiter #(.N(8), .REQS(4), .HOLD_CYCLES(2), .CNT_W(8)) dut_a (
    .clk(clk), .res(res_a), .req(req_a), .din(din_a), .gnt(gnt_a),
    .busy(busy_a), .q(q_a), .last_id(last_a), .wr_cnt(cnt_a)
  );

  ff_wr_arbiter #(.N(8), .REQS(4), .HOLD_CYCLES(0), .CNT_W(4)) dut_b (
    .clk(clk), .res(res_b), .req(req_b), .din(din_b), .gnt(gnt_b),
    .busy(busy_b), .q(q_b), .last_id(last_b), .wr_cnt(cnt_b)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  gnt;
    logic        busy;
    logic [7:0]  q;
    logic [1:0]  last;
    logic [7:0]  cnt;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [3:0] req, input logic [31:0] din,
                     input logic [3:0] gnt, input logic busy, input logic [7:0] q,
                     input logic [1:0] last, input logic [7:0] cnt, input string name);
    vec_t v;
    v.rst = rst; v.req = req; v.din = din; v.gnt = gnt; v.busy = busy;
    v.q = q; v.last = last; v.cnt = cnt; v.name = name;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] onehot(input int id);
    logic [3:0] r;
    r = 4'b0001 << id;
    return r;
  endfunction

  initial begin
    logic [31:0] da, ds;
    logic [7:0]  qv, pq;
    logic [1:0]  pl;
    logic [3:0]  r;
    int          id;

    res_a = 1'b1; res_b = 1'b1;
    req_a = '0;   req_b = '0;
    din_a = '0;   din_b = '0;

    // Single write from requester 1, then idle.
    da = 32'h0000_A500;
    add(1, 4'b0000, 32'h0, 4'b0000, 0, 8'h00, 2'd3, 8'd0, "reset");
    add(0, 4'b0010, da, 4'b0010, 1, 8'h00, 2'd3, 8'd0, "single_grant");
    add(0, 4'b0010, da, 4'b0000, 1, 8'hA5, 2'd1, 8'd1, "single_commit");
    add(0, 4'b0000, da, 4'b0000, 1, 8'hA5, 2'd1, 8'd1, "single_hold1");
    add(0, 4'b0000, da, 4'b0000, 0, 8'hA5, 2'd1, 8'd1, "single_hold2");
    add(0, 4'b0000, da, 4'b0000, 0, 8'hA5, 2'd1, 8'd1, "single_idle");

    // Saturation from reset: grants 0,1,2,3,0, one every 4 cycles.
    ds = 32'h4433_2211;
    add(1, 4'b0000, 32'h0, 4'b0000, 0, 8'h00, 2'd3, 8'd0, "sat_reset");
    for (int g = 0; g < 5; g++) begin
      id = g % 4;
      qv = 8'(8'h11 * (id + 1));
      pl = (g == 0) ? 2'd3 : 2'((g - 1) % 4);
      pq = (g == 0) ? 8'h00 : 8'(8'h11 * (int'(pl) + 1));
      r  = (g == 4) ? 4'b0000 : 4'b1111;
      add(0, 4'b1111, ds, onehot(id), 1, pq, pl, 8'(g), "sat_grant");
      add(0, 4'b1111, ds, 4'b0000, 1, qv, 2'(id), 8'(g + 1), "sat_commit");
      add(0, r, ds, 4'b0000, 1, qv, 2'(id), 8'(g + 1), "sat_hold1");
      add(0, r, ds, 4'b0000, 0, qv, 2'(id), 8'(g + 1), "sat_hold2");
    end

    // Withdraw during LOAD, then a full request picks last_id+1.
    add(0, 4'b0100, ds, 4'b0100, 1, 8'h11, 2'd0, 8'd5, "wd_grant");
    add(0, 4'b0000, ds, 4'b0000, 0, 8'h11, 2'd0, 8'd5, "wd_abort");
    add(0, 4'b1111, ds, 4'b0010, 1, 8'h11, 2'd0, 8'd5, "wd_regrant");
    add(0, 4'b1111, ds, 4'b0000, 1, 8'h22, 2'd1, 8'd6, "wd_commit");
    add(0, 4'b0000, ds, 4'b0000, 1, 8'h22, 2'd1, 8'd6, "wd_hold1");
    add(0, 4'b0000, ds, 4'b0000, 0, 8'h22, 2'd1, 8'd6, "wd_hold2");

    #2;
    foreach (tbl[i]) begin
      res_a = tbl[i].rst;
      req_a = tbl[i].req;
      din_a = tbl[i].din;
      step();
      check({tbl[i].name, ".gnt"},  32'(gnt_a),  32'(tbl[i].gnt));
      check({tbl[i].name, ".busy"}, 32'(busy_a), 32'(tbl[i].busy));
      check({tbl[i].name, ".q"},    32'(q_a),    32'(tbl[i].q));
      check({tbl[i].name, ".last"}, 32'(last_a), 32'(tbl[i].last));
      check({tbl[i].name, ".cnt"},  32'(cnt_a),  32'(tbl[i].cnt));
    end

    // Asynchronous reset while in LOAD with q=0x3C.
    req_a = 4'b0001; din_a = 32'h0000_003C;
    step();
    check("rst_pre.gnt", 32'(gnt_a), 32'h1);
    step();
    check("rst_pre.q", 32'(q_a), 32'h3C);
    req_a = 4'b0000;
    step(); step();
    req_a = 4'b0010; din_a = 32'h0000_993C;
    step();
    check("rst_load.gnt", 32'(gnt_a), 32'h2);
    #3 res_a = 1'b1;
    #1;
    check("rst_async.q",    32'(q_a),    32'h0);
    check("rst_async.gnt",  32'(gnt_a),  32'h0);
    check("rst_async.busy", 32'(busy_a), 32'h0);
    check("rst_async.last", 32'(last_a), 32'h3);
    check("rst_async.cnt",  32'(cnt_a),  32'h0);
    step();
    req_a = 4'b0000;
    res_a = 1'b0;
    step(); step(); step();
    check("rst_after.q",    32'(q_a),    32'h0);
    check("rst_after.cnt",  32'(cnt_a),  32'h0);
    check("rst_after.busy", 32'(busy_a), 32'h0);

    // HOLD_CYCLES=0, CNT_W=4: alternating 0,1 grants, counter wraps after 16.
    check("b_reset.last", 32'(last_b), 32'h3);
    check("b_reset.cnt",  32'(cnt_b),  32'h0);
    res_b = 1'b0;
    req_b = 4'b0011; din_b = 32'h0000_0B0A;
    for (int w = 1; w <= 17; w++) begin
      id = (w - 1) % 2;
      step();
      check("b_grant.gnt",  32'(gnt_b),  32'(onehot(id)));
      check("b_grant.busy", 32'(busy_b), 32'h1);
      step();
      check("b_commit.q",    32'(q_b),    (id == 1) ? 32'h0B : 32'h0A);
      check("b_commit.last", 32'(last_b), 32'(id));
      check("b_commit.cnt",  32'(cnt_b),  32'(w % 16));
      check("b_commit.busy", 32'(busy_b), 32'h0);
    end
    req_b = 4'b0000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
